seq_mult_vr_param: RTL and testbench

Parametrised sequential shift-add multiplier with controller and datapath in one block, and valid/ready handshakes on both sides. Supports signed and unsigned operands, selected per transaction. Accepts a new operand pair in the same cycle a finished result is consumed, so back-to-back transactions need no idle cycle. Sits between an operand producer (src) and a result consumer (dst) in the multiplier test harness.

---
 rtl/seq_mult_pkg.sv | 12 +
 rtl/seq_mult_datapath.sv | 75 +++++++
 rtl/seq_mult_vr_param.sv | 86 ++++++++
 tb/tb_seq_mult_vr_param.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/seq_mult_pkg.sv
// Shared types and defaults for the sequential shift-add multiplier.
package seq_mult_pkg;

  localparam int unsigned DEF_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mult_state_t;

endpackage : seq_mult_pkg

// File: rtl/seq_mult_datapath.sv
// Datapath of the shift-add multiplier: operand magnitudes, accumulator,
// iteration counter, sign fix-up and the product register.
// Ports:
//   clk, reset_i            clock, async active-low reset
//   load_i                  capture new operands, clear accumulator/counter
//   step_i                  process one multiplier bit
//   commit_i                (with step_i) write the signed-corrected product
//   a_i, b_i, is_signed_i   operands and signedness, sampled on load_i
//   last_iter_o             counter is on its final iteration
//   product_o               registered 2*WIDTH result
module seq_mult_datapath
  import seq_mult_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               reset_i,
  input  logic               load_i,
  input  logic               step_i,
  input  logic               commit_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic               is_signed_i,
  output logic               last_iter_o,
  output logic [2*WIDTH-1:0] product_o
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned PW    = 2 * WIDTH;

  logic [WIDTH-1:0] a_q, b_q;
  logic [PW-1:0]    acc_q, product_q;
  logic [CNT_W-1:0] cnt_q;
  logic             neg_q;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [PW-1:0]    acc_sum;

  // Magnitudes; -2^(W-1) maps to 2^(W-1), which fits as W-bit unsigned.
  always_comb begin
    a_mag   = (is_signed_i && a_i[WIDTH-1]) ? WIDTH'(-a_i) : a_i;
    b_mag   = (is_signed_i && b_i[WIDTH-1]) ? WIDTH'(-b_i) : b_i;
    acc_sum = acc_q + (b_q[0] ? (PW'({WIDTH'(0), a_q}) << cnt_q) : PW'(0));
  end

  // Operand, accumulator, counter and product registers.
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
    end else if (load_i) begin
      a_q   <= a_mag;
      b_q   <= b_mag;
      neg_q <= is_signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
      acc_q <= '0;
      cnt_q <= '0;
    end else if (step_i) begin
      acc_q <= acc_sum;
      b_q   <= b_q >> 1;
      cnt_q <= cnt_q + CNT_W'(1);
      // Final step folds the last partial product in before the sign fix.
      if (commit_i) begin
        product_q <= neg_q ? PW'(-acc_sum) : acc_sum;
      end
    end
  end

  assign last_iter_o = (cnt_q == CNT_W'(WIDTH - 1));
  assign product_o   = product_q;

endmodule : seq_mult_datapath

// File: rtl/seq_mult_vr_param.sv
// Sequential shift-add multiplier with valid/ready on operand and result
// sides; signed or unsigned per transaction, WIDTH-cycle latency, and a new
// accept allowed on the same edge a result is consumed.
// Ports:
//   clk, reset                    clock, async active-low reset
//   src_valid/src_ready           operand handshake (src_ready is
//                                 combinational from dst_ready in DONE)
//   multiplicand, multiplier      operands A and B
//   is_signed                     1 = two's complement operands
//   dst_valid/dst_ready           result handshake
//   product                       2*WIDTH result, stable while dst_valid=1
module seq_mult_vr_param
  import seq_mult_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               src_valid,
  output logic               src_ready,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic               is_signed,
  output logic               dst_valid,
  input  logic               dst_ready,
  output logic [2*WIDTH-1:0] product
);

  mult_state_t state_q;
  logic        dst_valid_q;
  logic        accept, step, commit, last_iter;

  // Ready in IDLE, or in DONE when the result leaves on this same edge.
  always_comb begin
    src_ready = (state_q == IDLE) || ((state_q == DONE) && dst_ready);
    accept    = src_valid && src_ready;
    step      = (state_q == BUSY);
    commit    = step && last_iter;
  end

  // Controller: sequencing and registered dst_valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      dst_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) state_q <= BUSY;
        end
        BUSY: begin
          if (last_iter) begin
            state_q     <= DONE;
            dst_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (dst_ready) begin
            dst_valid_q <= 1'b0;
            state_q     <= src_valid ? BUSY : IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          dst_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign dst_valid = dst_valid_q;

  seq_mult_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk         (clk),
    .reset_i     (reset),
    .load_i      (accept),
    .step_i      (step),
    .commit_i    (commit),
    .a_i         (multiplicand),
    .b_i         (multiplier),
    .is_signed_i (is_signed),
    .last_iter_o (last_iter),
    .product_o   (product)
  );

endmodule : seq_mult_vr_param

// File: tb/tb_seq_mult_vr_param.sv
// Directed bench for seq_mult_vr_param at WIDTH=16.
module tb_seq_mult_vr_param;
  import seq_mult_pkg::*;

  localparam int unsigned W = 16;

  logic          clk;
  logic          reset;
  logic          src_valid;
  logic          src_ready;
  logic [W-1:0]  multiplicand;
  logic [W-1:0]  multiplier;
  logic          is_signed;
  logic          dst_valid;
  logic          dst_ready;
  logic [2*W-1:0] product;

  int n_checks;
  int n_pass;

  seq_mult_vr_param #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .src_valid    (src_valid),
    .src_ready    (src_ready),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .is_signed    (is_signed),
    .dst_valid    (dst_valid),
    .dst_ready    (dst_ready),
    .product      (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for dst_valid; returns cycles waited.
  task automatic wait_result(output int cyc);
    cyc = 0;
    while (!dst_valid && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  // Single transaction with dst_ready=1: latency, product, return to IDLE.
  task automatic run_txn(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic [2*W-1:0] exp);
    int cyc;
    dst_ready    = 1'b1;
    src_valid    = 1'b1;
    multiplicand = a;
    multiplier   = b;
    is_signed    = s;
    tick();
    src_valid    = 1'b0;
    multiplicand = ~a;
    multiplier   = ~b;
    wait_result(cyc);
    check({tag, "_lat"}, 64'(cyc), 64'd16);
    check({tag, "_prod"}, 64'(product), 64'(exp));
    tick();
    check({tag, "_idle_rdy"}, 64'(src_ready), 64'd1);
    check({tag, "_idle_vld"}, 64'(dst_valid), 64'd0);
  endtask

  initial begin
    int cyc;
    logic [2*W-1:0] held;
    n_checks     = 0;
    n_pass       = 0;
    reset        = 1'b0;
    src_valid    = 1'b0;
    dst_ready    = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    is_signed    = 1'b0;
    #12;
    check("rst_src_ready", 64'(src_ready), 64'd1);
    check("rst_dst_valid", 64'(dst_valid), 64'd0);
    check("rst_product", 64'(product), 64'd0);
    reset = 1'b1;
    tick();

    run_txn("u3x5", 16'd3, 16'd5, 1'b0, 32'h0000_000F);
    run_txn("s_m3x5", 16'hFFFD, 16'h0005, 1'b1, 32'hFFFF_FFF1);
    run_txn("u_fffdx5", 16'hFFFD, 16'h0005, 1'b0, 32'h0004_FFF1);
    run_txn("s_minxmin", 16'h8000, 16'h8000, 1'b1, 32'h4000_0000);
    run_txn("u_maxxmax", 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001);
    run_txn("s_0xm1", 16'h0000, 16'hFFFF, 1'b1, 32'h0000_0000);

    // Backpressure: result held for 10 cycles with dst_ready low.
    dst_ready    = 1'b0;
    src_valid    = 1'b1;
    multiplicand = 16'd100;
    multiplier   = 16'd300;
    is_signed    = 1'b0;
    tick();
    src_valid = 1'b0;
    wait_result(cyc);
    check("bp_lat", 64'(cyc), 64'd16);
    check("bp_prod", 64'(product), 64'd30000);
    held = product;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_hold_vld", 64'(dst_valid), 64'd1);
      check("bp_hold_prod", 64'(product), 64'(held));
      check("bp_hold_rdy", 64'(src_ready), 64'd0);
    end
    dst_ready = 1'b1;
    #1;
    check("bp_rdy_comb", 64'(src_ready), 64'd1);
    tick();
    check("bp_after_vld", 64'(dst_valid), 64'd0);
    check("bp_after_rdy", 64'(src_ready), 64'd1);

    // Back-to-back: 2x7 then 9x9 with src_valid held high.
    dst_ready    = 1'b1;
    src_valid    = 1'b1;
    multiplicand = 16'd2;
    multiplier   = 16'd7;
    is_signed    = 1'b0;
    tick();
    multiplicand = 16'd9;
    multiplier   = 16'd9;
    wait_result(cyc);
    check("b2b1_lat", 64'(cyc), 64'd16);
    check("b2b1_prod", 64'(product), 64'd14);
    check("b2b1_src_rdy", 64'(src_ready), 64'd1);
    tick();
    src_valid = 1'b0;
    check("b2b_xfer_vld", 64'(dst_valid), 64'd0);
    check("b2b_busy_rdy", 64'(src_ready), 64'd0);
    wait_result(cyc);
    check("b2b2_lat", 64'(cyc), 64'd16);
    check("b2b2_prod", 64'(product), 64'd81);
    tick();

    // Reset pulse mid-BUSY, then a clean 4x4.
    src_valid    = 1'b1;
    multiplicand = 16'h1234;
    multiplier   = 16'h5678;
    tick();
    src_valid = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    reset = 1'b0;
    #1;
    check("abort_vld", 64'(dst_valid), 64'd0);
    check("abort_prod", 64'(product), 64'd0);
    check("abort_rdy", 64'(src_ready), 64'd1);
    #1;
    reset = 1'b1;
    tick();
    run_txn("post_rst_4x4", 16'd4, 16'd4, 1'b0, 32'd16);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_seq_mult_vr_param
